// File: rtl/max_pool_stream.sv
// Streaming 1-D max pool: window P, stride P, N samples per frame, tail of N mod P dropped.
// One-cycle latency from the last sample of a window; x_ready drops only when a finished window cannot unload.
module max_pool_stream #(
   parameter int N = 121,
   parameter int P = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] x_data,
   input  logic        x_valid,
   output logic        x_ready,
   output logic [15:0] y_data,
   output logic        y_valid,
   input  logic        y_ready
);

   localparam int  SW       = (N > 1) ? $clog2(N) : 1;
   localparam int  WW       = $clog2(P);
   localparam int  LAST_WIN = P * (N / P) - 1;
   localparam bit  HAS_TAIL = (N % P) != 0;

   typedef enum logic {ACCUM, DISCARD} state_t;

   state_t             state;
   logic [SW-1:0]      s;
   logic [WW-1:0]      w;
   logic signed [15:0] m;
   logic signed [15:0] xs;
   logic signed [15:0] maxv;
   logic               last_w;
   logic               x_hs;
   logic               win_done;

   assign xs       = $signed(x_data);
   assign maxv     = (xs > m) ? xs : m;
   assign last_w   = (w == WW'(P - 1));
   assign x_ready  = (state == DISCARD) || !(last_w && y_valid && !y_ready);
   assign x_hs     = x_valid && x_ready;
   assign win_done = x_hs && (state == ACCUM) && last_w;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ACCUM;
         s       <= '0;
         w       <= '0;
         m       <= '0;
         y_data  <= '0;
         y_valid <= 1'b0;
      end else begin
         // A completing window reloads the output even while the old result is unloading.
         if (win_done) begin
            y_data  <= $unsigned(maxv);
            y_valid <= 1'b1;
         end else if (y_valid && y_ready) begin
            y_valid <= 1'b0;
         end

         if (x_hs) begin
            if (state == ACCUM) begin
               if (last_w) begin
                  w <= '0;
               end else begin
                  w <= w + 1'b1;
                  m <= (w == '0) ? xs : maxv;
               end
            end

            if (s == SW'(N - 1)) begin
               s     <= '0;
               w     <= '0;
               state <= ACCUM;
            end else begin
               s <= s + 1'b1;
               if (win_done && HAS_TAIL && (s == SW'(LAST_WIN)))
                  state <= DISCARD;
            end
         end
      end
   end

endmodule

// File: tb/tb_max_pool_stream.sv
// Bench for max_pool_stream: N=121/P=2 instance against a frame-level reference, plus an N=8/P=3 instance.
module tb_max_pool_stream;

   localparam int N = 121;
   localparam int P = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] x_data = '0;
   logic        x_valid = 1'b0;
   logic        x_ready;
   logic [15:0] y_data;
   logic        y_valid;
   logic        y_ready = 1'b0;

   logic [15:0] x_data3 = '0;
   logic        x_valid3 = 1'b0;
   logic        x_ready3;
   logic [15:0] y_data3;
   logic        y_valid3;
   logic        y_ready3 = 1'b0;

   int total = 0;
   int bad = 0;

   logic signed [15:0] frame[$];
   logic [15:0]        expq[$];

   always #5 clk = ~clk;

   max_pool_stream #(.N(N), .P(P)) dut (
      .clk(clk), .reset(reset),
      .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
      .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready)
   );

   max_pool_stream #(.N(8), .P(3)) dut3 (
      .clk(clk), .reset(reset),
      .x_data(x_data3), .x_valid(x_valid3), .x_ready(x_ready3),
      .y_data(y_data3), .y_valid(y_valid3), .y_ready(y_ready3)
   );

   // Reference: collect the frame, emit max of each full window, drop the tail.
   task automatic model_push(input logic [15:0] x);
      int idx;
      logic signed [15:0] mx;
      frame.push_back($signed(x));
      idx = frame.size() - 1;
      if (idx < P * (N / P) && ((idx + 1) % P) == 0) begin
         mx = frame[idx - P + 1];
         for (int j = idx - P + 2; j <= idx; j++)
            if (frame[j] > mx) mx = frame[j];
         expq.push_back($unsigned(mx));
      end
      if (frame.size() == N) frame.delete();
   endtask

   task automatic model_clear();
      frame.delete();
      expq.delete();
   endtask

   task automatic step(input logic xv, input logic [15:0] xd, input logic yr,
                       output logic xr, output logic yv, output logic [15:0] yd);
      @(negedge clk);
      x_valid = xv;
      x_data  = xd;
      y_ready = yr;
      #1;
      xr = x_ready;
      yv = y_valid;
      yd = y_data;
      if (xv && xr) model_push(xd);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      x_valid  = 1'b0;
      y_ready  = 1'b0;
      x_valid3 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      total++;
      if (y_valid !== 1'b0 || y_data !== 16'd0) begin
         bad++;
         $display("FAIL reset_out: y_valid=%b y_data=%h, want 0/0000", y_valid, y_data);
      end
      total++;
      if (y_valid3 !== 1'b0 || y_data3 !== 16'd0) begin
         bad++;
         $display("FAIL reset_out3: y_valid=%b y_data=%h, want 0/0000", y_valid3, y_data3);
      end
      reset = 1'b0;
      model_clear();
      @(negedge clk);
      #1;
      total++;
      if (x_ready !== 1'b1 || x_ready3 !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready: x_ready=%b x_ready3=%b, want 1/1", x_ready, x_ready3);
      end
   endtask

   // Ramp frame plus two samples of the next frame, continuous valid/ready.
   task automatic test_ramp();
      logic xr, yv;
      logic [15:0] yd, e, c;
      int nout = 0;
      do_reset();
      for (int i = 0; i < 124; i++) begin
         if (i < 121) e = 16'(i);
         else if (i == 121) e = 16'd200;
         else e = 16'd50;
         step(i < 123, e, 1'b1, xr, yv, yd);
         total++;
         if (xr !== 1'b1) begin
            bad++;
            $display("FAIL ramp_ready: cycle %0d x_ready=%b, want 1", i, xr);
         end
         total++;
         if (yv !== ((i >= 2 && i <= 120 && i % 2 == 0) || i == 123)) begin
            bad++;
            $display("FAIL ramp_cadence: cycle %0d y_valid=%b", i, yv);
         end
         if (yv === 1'b1) begin
            c = (nout < 60) ? 16'(2 * nout + 1) : 16'd200;
            e = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
            total++;
            if (yd !== c || yd !== e) begin
               bad++;
               $display("FAIL ramp_data: output %0d y_data=%0d, want %0d (model %0d)", nout, yd, c, e);
            end
            nout++;
         end
      end
      total++;
      if (nout != 61) begin
         bad++;
         $display("FAIL ramp_count: got %0d outputs, want 61", nout);
      end
   endtask

   task automatic test_signed();
      logic xr, yv;
      logic [15:0] yd, e;
      logic [15:0] ins [4];
      logic [15:0] want [2];
      int nout = 0;
      ins  = '{16'hFFFB, 16'hFFF7, 16'd7, 16'd7};
      want = '{16'hFFFB, 16'd7};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(i < 4, (i < 4) ? ins[i] : 16'd0, 1'b1, xr, yv, yd);
         if (yv === 1'b1) begin
            e = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
            total++;
            if (nout > 1 || yd !== want[nout] || yd !== e) begin
               bad++;
               $display("FAIL signed_max: output %0d y_data=%h, model %h", nout, yd, e);
            end
            nout++;
         end
      end
      total++;
      if (nout != 2) begin
         bad++;
         $display("FAIL signed_count: got %0d outputs, want 2", nout);
      end
   endtask

   task automatic test_backpressure();
      logic xr, yv;
      logic [15:0] yd;
      do_reset();
      step(1'b1, 16'd1, 1'b1, xr, yv, yd);
      step(1'b1, 16'd3, 1'b1, xr, yv, yd);
      step(1'b1, 16'd10, 1'b0, xr, yv, yd);
      total++;
      if (xr !== 1'b1 || yv !== 1'b1 || yd !== 16'd3) begin
         bad++;
         $display("FAIL bp_first: x_ready=%b y_valid=%b y_data=%0d, want 1/1/3", xr, yv, yd);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 16'd2, 1'b0, xr, yv, yd);
         total++;
         if (xr !== 1'b0 || yv !== 1'b1 || yd !== 16'd3) begin
            bad++;
            $display("FAIL bp_stall: x_ready=%b y_valid=%b y_data=%0d, want 0/1/3", xr, yv, yd);
         end
      end
      step(1'b1, 16'd2, 1'b1, xr, yv, yd);
      total++;
      if (xr !== 1'b1 || yv !== 1'b1 || yd !== 16'd3) begin
         bad++;
         $display("FAIL bp_release: x_ready=%b y_valid=%b y_data=%0d, want 1/1/3", xr, yv, yd);
      end
      void'(expq.pop_front());
      step(1'b0, 16'd0, 1'b1, xr, yv, yd);
      total++;
      if (yv !== 1'b1 || yd !== 16'd10) begin
         bad++;
         $display("FAIL bp_next: y_valid=%b y_data=%0d, want 1/10", yv, yd);
      end
      void'(expq.pop_front());
      step(1'b0, 16'd0, 1'b1, xr, yv, yd);
      total++;
      if (yv !== 1'b0) begin
         bad++;
         $display("FAIL bp_clear: y_valid=%b, want 0", yv);
      end
   endtask

   task automatic test_random();
      logic xr, yv, hold;
      logic [15:0] yd, pyd, e;
      int k;
      hold = 1'b0;
      pyd  = '0;
      do_reset();
      for (int i = 0; i < 900; i++) begin
         step($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 6, xr, yv, yd);
         if (hold) begin
            total++;
            if (yv !== 1'b1 || yd !== pyd) begin
               bad++;
               $display("FAIL rand_hold: cycle %0d y_valid=%b y_data=%h, want 1/%h", i, yv, yd, pyd);
            end
         end
         hold = yv && !y_ready;
         pyd  = yd;
         if (yv === 1'b1 && y_ready) begin
            e = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
            total++;
            if (yd !== e) begin
               bad++;
               $display("FAIL rand_data: cycle %0d y_data=%h, want %h", i, yd, e);
            end
         end
      end
      k = 0;
      while (k < 20 && expq.size() > 0) begin
         step(1'b0, 16'd0, 1'b1, xr, yv, yd);
         if (yv === 1'b1) begin
            e = expq.pop_front();
            total++;
            if (yd !== e) begin
               bad++;
               $display("FAIL rand_drain: y_data=%h, want %h", yd, e);
            end
         end
         k++;
      end
      total++;
      if (expq.size() != 0) begin
         bad++;
         $display("FAIL rand_left: %0d expected outputs never appeared", expq.size());
      end
   endtask

   task automatic test_mid_reset();
      logic xr, yv;
      logic [15:0] yd, e;
      int nout = 0;
      do_reset();
      step(1'b1, 16'd5, 1'b0, xr, yv, yd);
      step(1'b1, 16'd9, 1'b0, xr, yv, yd);
      step(1'b1, 16'd4, 1'b0, xr, yv, yd);
      total++;
      if (yv !== 1'b1 || yd !== 16'd9) begin
         bad++;
         $display("FAIL mid_pre: y_valid=%b y_data=%0d, want 1/9", yv, yd);
      end
      @(negedge clk);
      reset   = 1'b1;
      x_valid = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if (y_valid !== 1'b0 || y_data !== 16'd0) begin
         bad++;
         $display("FAIL mid_reset: y_valid=%b y_data=%h, want 0/0000", y_valid, y_data);
      end
      reset = 1'b0;
      model_clear();
      for (int i = 0; i < 123; i++) begin
         step(i < 121, 16'($urandom), 1'b1, xr, yv, yd);
         if (yv === 1'b1) begin
            e = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
            total++;
            if (yd !== e) begin
               bad++;
               $display("FAIL mid_data: output %0d y_data=%h, want %h", nout, yd, e);
            end
            nout++;
         end
      end
      total++;
      if (nout != 60) begin
         bad++;
         $display("FAIL mid_count: got %0d outputs, want 60", nout);
      end
   endtask

   task automatic test_p3_tail();
      logic [15:0] seq [11];
      logic [15:0] want [3];
      int nout = 0;
      seq  = '{16'd4, 16'd0, 16'd9, 16'd1, 16'd8, 16'd2, 16'd5, 16'd6, 16'd1, 16'd2, 16'd3};
      want = '{16'd9, 16'd8, 16'd3};
      do_reset();
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         x_valid3 = (i < 11);
         x_data3  = (i < 11) ? seq[i] : 16'd0;
         y_ready3 = 1'b1;
         #1;
         if (i < 11) begin
            total++;
            if (x_ready3 !== 1'b1) begin
               bad++;
               $display("FAIL p3_ready: sample %0d x_ready=%b, want 1", i, x_ready3);
            end
         end
         if (y_valid3 === 1'b1) begin
            total++;
            if (nout > 2 || y_data3 !== want[nout]) begin
               bad++;
               $display("FAIL p3_data: output %0d y_data=%0d", nout, y_data3);
            end
            nout++;
         end
      end
      x_valid3 = 1'b0;
      total++;
      if (nout != 3) begin
         bad++;
         $display("FAIL p3_count: got %0d outputs, want 3", nout);
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_signed();
      test_backpressure();
      test_random();
      test_mid_reset();
      test_p3_tail();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/max_pool_stream.md
MAX_POOL_STREAM -- requirements
Module: max_pool_stream

Interface
- REQ-001: Parameter N, default 121, SHALL be the number of input samples per frame (conv output length 128-8+1).
- REQ-002: Parameter P, default 2, SHALL be the pool window and stride, with 2 <= P <= N.
- REQ-003: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
- REQ-004: reset  input  1  SHALL be a synchronous, active-high reset.
- REQ-005: x_data  input  16  SHALL be the signed input sample (ReLU'd conv output).
- REQ-006: x_valid  input  1  SHALL indicate that x_data is valid.
- REQ-007: x_ready  output  1  SHALL indicate that the block accepts x_data this cycle.
- REQ-008: y_data  output  16  SHALL be the signed pooled result.
- REQ-009: y_valid  output  1  SHALL indicate that y_data is valid.
- REQ-010: y_ready  input  1  SHALL indicate that the consumer accepts y_data this cycle.

Function
- REQ-011: An input handshake SHALL occur when x_valid && x_ready; an output handshake SHALL occur when y_valid && y_ready.
- REQ-012: The block SHALL keep a sample counter s (0..N-1), a window counter w (0..P-1), a signed 16-bit running max m and a state register with states ACCUM and DISCARD.
- REQ-013: Each frame SHALL produce floor(N/P) outputs; the last N mod P samples of the frame SHALL be accepted and dropped in DISCARD.
- REQ-014: In ACCUM, an input handshake with w==0 SHALL load m <= x_data, ignoring the old m.
- REQ-015: In ACCUM, an input handshake with 0<w<P-1 SHALL set m <= max(m, x_data) under signed comparison.
- REQ-016: In ACCUM, an input handshake with w==P-1 SHALL load y_data <= max(m, x_data), set y_valid=1 on the next cycle and set w <= 0.
- REQ-017: Latency SHALL be one cycle: y_valid rises in the cycle after the window's final input handshake.
- REQ-018: In ACCUM, x_ready SHALL be 1 except when w==P-1 && y_valid && !y_ready, in which case it SHALL be 0 (backpressure).
- REQ-019: In DISCARD, x_ready SHALL be 1; accepted samples SHALL NOT affect m, y_data or y_valid.
- REQ-020: After a window completes, the state SHALL go to DISCARD if s+1 == P*floor(N/P) and N mod P != 0; otherwise it SHALL stay in ACCUM.
- REQ-021: On the handshake of the frame's last sample (s==N-1), s SHALL become 0, w SHALL become 0 and the state SHALL become ACCUM; otherwise each input handshake increments s.
- REQ-022: While y_valid && !y_ready, y_data and y_valid SHALL hold stable.
- REQ-023: An output handshake with no window completion in the same cycle SHALL clear y_valid on the next cycle.
- REQ-024: An output handshake in the same cycle as a window completion SHALL load the new result and keep y_valid=1, with no bubble.
- REQ-025: Samples of equal value SHALL produce that value; no arithmetic SHALL widen or saturate (max only).
- REQ-026: Frames SHALL be processed back-to-back with no idle cycles required between them.

Reset
- REQ-027: While reset is high at a clock edge, y_valid SHALL be 0, y_data SHALL be 0, m SHALL be 0, s and w SHALL be 0 and the state SHALL be ACCUM.
- REQ-028: Reset mid-frame SHALL discard all partial window and frame progress; the next accepted sample SHALL be sample 0 of a new frame.
- REQ-029: x_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
- REQ-030: N=121, P=2, y_ready=1, x_valid=1, x = 0,1,...,120 -> 60 outputs 1,3,...,119; sample 120 is dropped; the next frame's first output comes from its samples 0 and 1.
- REQ-031: P=2, inputs -5,-9 -> y_data = -5 (signed compare); inputs 7,7 -> y_data = 7.
- REQ-032: y_ready=0 after first output 3 (inputs 1,3), then inputs 10,2 -> x_ready=0 at the 2nd sample of the pending window, y_data holds 3; when y_ready=1, 3 is accepted and y_data = 10 next cycle.
- REQ-033: Continuous x_valid=1, y_ready=1, P=2 -> x_ready stays 1 throughout and one output is produced every 2 cycles with no bubble.
- REQ-034: Reset asserted after 3 samples of a frame -> y_valid=0 and y_data=0; a fresh 121-sample frame then yields exactly 60 correct outputs.
- REQ-035: N=8, P=3, x = 4,0,9,1,8,2,5,6 -> outputs 9 and 8; samples 5 and 6 are discarded.
